adc_pll_supervisor: RTL and testbench

- Free-running controller on the 50 MHz board reference clock; drives the ADC PLL reset input and consumes its lock output.
- Sequences PLL reset, qualifies lock with a timeout and a stability window, then releases the downstream ADC/Ethernet reset.
- Detects loss of lock, re-runs the sequence, counts relock events and flags a fault after repeated lock timeouts.

---
 rtl/adc_pll_pkg.sv | 24 ++
 rtl/adc_sync_2ff.sv | 25 ++
 rtl/adc_pll_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_adc_pll_supervisor.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pll_pkg.sv
// Shared types and constants for the ADC PLL supervisor.
package adc_pll_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } sup_state_t;

  localparam int unsigned RELOCK_CNT_W    = 8;
  localparam int unsigned GLITCH_FILT_CYC = 4;

  // Saturating increment for the relock event counter (sticks at all-ones).
  function automatic logic [RELOCK_CNT_W-1:0] sat_inc_relock(input logic [RELOCK_CNT_W-1:0] v);
    if (v == {RELOCK_CNT_W{1'b1}}) begin
      sat_inc_relock = v;
    end else begin
      sat_inc_relock = v + RELOCK_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/adc_sync_2ff.sv
// Two-flop synchroniser for an asynchronous status level; clears to 0 on reset.
module adc_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages to resolve metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_pll_supervisor.sv
// ADC PLL supervisor: sequences PLL reset, qualifies lock (timeout and
// stability window), releases the downstream reset, and counts relocks.
// Optional build macro ADC_PLL_SUP_GLITCH_FILTER_EN: require four
// consecutive low lock samples in RUN before declaring loss of lock.
module adc_pll_supervisor
  import adc_pll_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRIES      = 4,
  parameter int unsigned CNT_W            = 17
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    force_relock,
  output logic                    pll_rst,
  output logic                    adc_rst_n,
  output logic                    ready,
  output logic                    fault,
  output logic [RELOCK_CNT_W-1:0] relock_count,
  output logic [2:0]              retry_count
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

  logic                    lk_s;
  logic                    run_loss_s;
  sup_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              retry_q, retry_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    pll_rst_q, pll_rst_d;
  logic                    adc_rst_n_q, adc_rst_n_d;
  logic                    ready_q, ready_d;
  logic                    fault_q, fault_d;

  adc_sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

`ifdef ADC_PLL_SUP_GLITCH_FILTER_EN
  localparam logic [1:0] FILT_LAST = 2'(GLITCH_FILT_CYC - 1);
  logic [1:0] filt_q, filt_d;

  // Count consecutive low lock samples in RUN; loss only on the last one
  always_comb begin
    filt_d     = 2'd0;
    run_loss_s = 1'b0;
    if (state_q == S_RUN) begin
      if (lk_s) begin
        filt_d = 2'd0;
      end else if (filt_q == FILT_LAST) begin
        run_loss_s = 1'b1;
      end else begin
        filt_d = filt_q + 2'd1;
      end
    end else begin
      filt_d = 2'd0;
    end
  end

  // Glitch filter counter, held at zero outside RUN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 2'd0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  // Any single low lock sample in RUN is a loss of lock
  always_comb begin
    run_loss_s = ~lk_s;
  end
`endif

  // Next-state, counter updates and output decode of the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    if (force_relock) begin
      state_d = S_RESET;
      cnt_d   = '0;
      retry_d = 3'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock has priority over a coincident timeout
          if (lk_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 3'd1;
            cnt_d   = '0;
            state_d = (retry_q == RETRY_LIMIT) ? S_FAULT : S_RESET;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state_d = S_RESET;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = 3'd0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (run_loss_s) begin
            relock_d = sat_inc_relock(relock_q);
            state_d  = S_RESET;
            cnt_d    = '0;
          end else begin
            state_d = S_RUN;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      endcase
    end
    pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
    adc_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  // FSM state, shared counter, event counters and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      retry_q     <= 3'd0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      adc_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      adc_rst_n_q <= adc_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign adc_rst_n    = adc_rst_n_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign relock_count = relock_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// Directed self-checking bench for adc_pll_supervisor.
// Inputs are driven and outputs sampled on the falling edge of refclk.
module tb_adc_pll_supervisor;

  localparam int unsigned RST_PULSE_CYC    = 4;
  localparam int unsigned LOCK_TIMEOUT_CYC = 100;
  localparam int unsigned LOCK_STABLE_CYC  = 16;
  localparam int unsigned MAX_RETRIES      = 2;
`ifdef ADC_PLL_SUP_GLITCH_FILTER_EN
  localparam int LOSS_LOW = 4;
`else
  localparam int LOSS_LOW = 1;
`endif

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       adc_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;
  logic [2:0] retry_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 refclk = ~refclk;

  adc_pll_supervisor #(
    .RST_PULSE_CYC    (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
    .MAX_RETRIES      (MAX_RETRIES),
    .CNT_W            (17)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .adc_rst_n    (adc_rst_n),
    .ready        (ready),
    .fault        (fault),
    .relock_count (relock_count),
    .retry_count  (retry_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1", name, ready, n);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    tick(3);
    tests_run++;
    if ({pll_rst, adc_rst_n, ready, fault} !== 4'b1000 || relock_count !== 8'd0 || retry_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_values: rst/adcn/rdy/flt=%b relock=%0d retry=%0d, required 1000 0 0",
               {pll_rst, adc_rst_n, ready, fault}, relock_count, retry_count);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    tick(3);
    tests_run++;
    if (pll_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL nom_pll_rst_held: pll_rst=%b, required 1", pll_rst);
    end
    tick(1);
    tests_run++;
    if (pll_rst !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL nom_pll_rst_release: pll_rst=%b ready=%b, required 0 0", pll_rst, ready);
    end
    tick(10);
    pll_locked = 1'b1;
    tick(18);
    tests_run++;
    if (ready !== 1'b0 || adc_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL nom_ready_early: ready=%b adc_rst_n=%b, required 0 0", ready, adc_rst_n);
    end
    tick(1);
    tests_run++;
    if ({pll_rst, adc_rst_n, ready, fault} !== 4'b0110 || retry_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL nom_run: rst/adcn/rdy/flt=%b retry=%0d, required 0110 0",
               {pll_rst, adc_rst_n, ready, fault}, retry_count);
    end
  endtask

  task automatic test_priority();
    pll_locked = 1'b0;
    tick(LOSS_LOW);
    pll_locked = 1'b1;
    tick(1);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tests_run++;
    if (relock_count !== 8'd0 || {pll_rst, adc_rst_n, ready, fault} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL prio_force_vs_loss: relock=%0d rst/adcn/rdy/flt=%b, required 0 1000",
               relock_count, {pll_rst, adc_rst_n, ready, fault});
    end
    wait_ready("prio_relock_ready");
  endtask

  task automatic test_lock_loss_run();
    for (int i = 1; i <= 300; i++) begin
      int exp_cnt;
      exp_cnt = (i > 255) ? 255 : i;
      pll_locked = 1'b0;
      tick(LOSS_LOW);
      pll_locked = 1'b1;
      tick(1);
      tests_run++;
      if (ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL loss_still_run[%0d]: ready=%b, required 1", i, ready);
      end
      tick(1);
      tests_run++;
      if (relock_count !== 8'(exp_cnt) || ready !== 1'b0 || adc_rst_n !== 1'b0 || pll_rst !== 1'b1) begin
        tests_failed++;
        $display("FAIL loss_detect[%0d]: relock=%0d ready=%b adc_rst_n=%b pll_rst=%b, required %0d 0 0 1",
                 i, relock_count, ready, adc_rst_n, pll_rst, exp_cnt);
      end
      tick(20);
      tests_run++;
      if (ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL loss_ready_early[%0d]: ready=%b, required 0", i, ready);
      end
      tick(1);
      tests_run++;
      if (ready !== 1'b1 || adc_rst_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL loss_resequence[%0d]: ready=%b adc_rst_n=%b, required 1 1", i, ready, adc_rst_n);
      end
    end
  endtask

  task automatic test_glitch_filter();
`ifdef ADC_PLL_SUP_GLITCH_FILTER_EN
    bit dropped = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (ready !== 1'b1) dropped = 1'b1;
    end
    tests_run++;
    if (dropped) begin
      tests_failed++;
      $display("FAIL glitch_3_low: ready dropped, required ready held 1");
    end
    pll_locked = 1'b0;
    tick(4);
    pll_locked = 1'b1;
    tick(1);
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_4_low_early: ready=%b, required 1", ready);
    end
    tick(1);
    tests_run++;
    if (ready !== 1'b0 || adc_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_4_low_loss: ready=%b adc_rst_n=%b, required 0 0", ready, adc_rst_n);
    end
`else
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_1_low_early: ready=%b, required 1", ready);
    end
    tick(1);
    tests_run++;
    if (ready !== 1'b0 || adc_rst_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_1_low_loss: ready=%b adc_rst_n=%b, required 0 0", ready, adc_rst_n);
    end
`endif
    wait_ready("glitch_relock_ready");
  endtask

  task automatic test_async_reset();
    pll_locked   = 1'b0;
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tests_run++;
    if (relock_count !== 8'd255 || pll_rst !== 1'b1 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL force_keeps_relock: relock=%0d pll_rst=%b ready=%b, required 255 1 0",
               relock_count, pll_rst, ready);
    end
    tick(4);
    tests_run++;
    if (pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_in_wait: pll_rst=%b, required 0", pll_rst);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pll_rst, adc_rst_n, ready, fault} !== 4'b1000 || relock_count !== 8'd0 || retry_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL arst_immediate: rst/adcn/rdy/flt=%b relock=%0d retry=%0d, required 1000 0 0",
               {pll_rst, adc_rst_n, ready, fault}, relock_count, retry_count);
    end
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_stability_break();
    bit early_ready = 1'b0;
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      if (k < 32 && ready !== 1'b0) early_ready = 1'b1;
      if (k == 10) begin
        tests_run++;
        if (pll_rst !== 1'b0) begin
          tests_failed++;
          $display("FAIL stab_still_stable: pll_rst=%b, required 0", pll_rst);
        end
      end
      if (k == 11) begin
        tests_run++;
        if (pll_rst !== 1'b1 || retry_count !== 3'd0) begin
          tests_failed++;
          $display("FAIL stab_back_to_reset: pll_rst=%b retry=%0d, required 1 0", pll_rst, retry_count);
        end
      end
      if (k == 31) begin
        tests_run++;
        if (early_ready) begin
          tests_failed++;
          $display("FAIL stab_no_ready: ready seen 1, required 0");
        end
      end
      if (k == 32) begin
        tests_run++;
        if (ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL stab_relock_run: ready=%b, required 1", ready);
        end
      end
      if (k == 8) pll_locked = 1'b0;
      if (k == 9) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout_fault();
    do_reset();
    tick(103);
    tests_run++;
    if (retry_count !== 3'd0 || pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_before_1: retry=%0d pll_rst=%b, required 0 0", retry_count, pll_rst);
    end
    tick(1);
    tests_run++;
    if (retry_count !== 3'd1 || pll_rst !== 1'b1 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_1: retry=%0d pll_rst=%b fault=%b, required 1 1 0", retry_count, pll_rst, fault);
    end
    tick(104);
    tests_run++;
    if (retry_count !== 3'd2 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_2: retry=%0d fault=%b, required 2 0", retry_count, fault);
    end
    tick(103);
    tests_run++;
    if (fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_fault_early: fault=%b, required 0", fault);
    end
    tick(1);
    tests_run++;
    if ({pll_rst, adc_rst_n, ready, fault} !== 4'b1001 || retry_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL to_fault: rst/adcn/rdy/flt=%b retry=%0d, required 1001 3",
               {pll_rst, adc_rst_n, ready, fault}, retry_count);
    end
    tick(50);
    tests_run++;
    if (fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_hold: fault=%b, required 1", fault);
    end
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tests_run++;
    if (fault !== 1'b0 || retry_count !== 3'd0 || pll_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_clear: fault=%b retry=%0d pll_rst=%b, required 0 0 1", fault, retry_count, pll_rst);
    end
    tick(3);
    tests_run++;
    if (pll_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_pulse: pll_rst=%b, required 1", pll_rst);
    end
    tick(1);
    tests_run++;
    if (pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_wait: pll_rst=%b, required 0", pll_rst);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_priority();
    test_lock_loss_run();
    test_glitch_filter();
    test_async_reset();
    test_stability_break();
    test_timeout_fault();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
